mole_hit_detector: RTL and testbench



---
 rtl/mole_hit_detector.sv | 233 +++++++++++++++++++++++
 tb/tb_mole_hit_detector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mole_hit_detector.sv
// mole_hit_detector: classifies player presses against the mole bus as hits
// or misses, detects unwhacked moles retracting (escapes), and keeps score,
// miss count, whacked mask and the IDLE/PLAYING/GAME_OVER state.
// Optional feature macro: MOLE_COMBO_EN (adds `combo` output and hit multiplier).
module mole_hit_detector #(
  parameter int NUM_HOLES   = 18,
  parameter int SCORE_WIDTH = 10,
  parameter int POINTS_HIT  = 1,
  parameter int POINTS_MISS = 1,
  parameter int MAX_MISSES  = 5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [NUM_HOLES-1:0]               mole_positions,
  input  logic [NUM_HOLES-1:0]               buttons,
  output logic [SCORE_WIDTH-1:0]             score,
  output logic [$clog2(MAX_MISSES+1)-1:0]    miss_count,
  output logic [NUM_HOLES-1:0]               whacked,
  output logic [NUM_HOLES-1:0]               hit_pulse,
  output logic                               miss_pulse,
  output logic                               playing,
  output logic                               game_over
`ifdef MOLE_COMBO_EN
  ,
  output logic [2:0]                         combo
`endif
);

  localparam int MW  = $clog2(MAX_MISSES + 1);
  localparam int CW  = $clog2(NUM_HOLES + 1);
  localparam int IW  = SCORE_WIDTH + $clog2(NUM_HOLES) + 2;
  localparam int MCW = MW + CW + 1;
  localparam logic [IW-1:0] SCORE_MAX = IW'((1 << SCORE_WIDTH) - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PLAYING   = 2'd1,
    S_GAME_OVER = 2'd2
  } state_t;

  function automatic logic [CW-1:0] popcount(input logic [NUM_HOLES-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  state_t                 state_q, state_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic [MW-1:0]          miss_count_q, miss_count_d;
  logic [NUM_HOLES-1:0]   whacked_q, whacked_d;
  logic [NUM_HOLES-1:0]   hit_pulse_q, hit_pulse_d;
  logic                   miss_pulse_q, miss_pulse_d;
  logic                   playing_q, playing_d;
  logic                   game_over_q, game_over_d;
  logic [NUM_HOLES-1:0]   prev_buttons_q, prev_buttons_d;
  logic [NUM_HOLES-1:0]   prev_moles_q, prev_moles_d;
`ifdef MOLE_COMBO_EN
  logic [2:0]             combo_q, combo_d;
`endif

  logic [NUM_HOLES-1:0]   press_s, hittable_s, esc_raw_s;
  logic [NUM_HOLES-1:0]   hit_vec_s, miss_vec_s, esc_vec_s;
  logic                   active_s;
  logic [CW-1:0]          nh_s, nm_s, ne_s;
  logic [CW:0]            miss_add_s;
  logic [IW-1:0]          mult_s, hit_pts_s, miss_pts_s, sum_s, score_nx_s;
  logic [MCW-1:0]         mc_sum_s;
  logic [MW-1:0]          mc_nx_s;

  // Classify this cycle's presses and retracting moles; only counted while playing.
  always_comb begin
    press_s    = buttons & ~prev_buttons_q;
    hittable_s = mole_positions & ~whacked_q;
    esc_raw_s  = prev_moles_q & ~mole_positions & ~whacked_q;
    active_s   = (state_q == S_PLAYING) && !start;
    if (active_s) begin
      hit_vec_s  = press_s & hittable_s;
      miss_vec_s = press_s & ~hittable_s;
      esc_vec_s  = esc_raw_s;
    end else begin
      hit_vec_s  = '0;
      miss_vec_s = '0;
      esc_vec_s  = '0;
    end
    nh_s       = popcount(hit_vec_s);
    nm_s       = popcount(miss_vec_s);
    ne_s       = popcount(esc_vec_s);
    miss_add_s = {1'b0, nm_s} + {1'b0, ne_s};
  end

  // Saturating score arithmetic (add hits, clamp high, then subtract misses, clamp at 0).
  always_comb begin
    mult_s = IW'(1);
`ifdef MOLE_COMBO_EN
    if (miss_add_s != '0) begin
      mult_s = IW'(1);
    end else begin
      case (combo_q)
        3'd0, 3'd1: mult_s = IW'(1);
        3'd2, 3'd3: mult_s = IW'(2);
        default:    mult_s = IW'(4);
      endcase
    end
`endif
    hit_pts_s  = IW'(nh_s) * IW'(POINTS_HIT) * mult_s;
    miss_pts_s = IW'(nm_s) * IW'(POINTS_MISS);
    sum_s      = IW'(score_q) + hit_pts_s;
    if (sum_s > SCORE_MAX) begin
      sum_s = SCORE_MAX;
    end else begin
      sum_s = sum_s;
    end
    if (miss_pts_s > sum_s) begin
      score_nx_s = '0;
    end else begin
      score_nx_s = sum_s - miss_pts_s;
    end
    mc_sum_s = MCW'(miss_count_q) + MCW'(miss_add_s);
    if (mc_sum_s >= MCW'(MAX_MISSES)) begin
      mc_nx_s = MW'(MAX_MISSES);
    end else begin
      mc_nx_s = mc_sum_s[MW-1:0];
    end
  end

  // Next game state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_PLAYING;
        else       state_d = S_IDLE;
      end
      S_PLAYING: begin
        if (start)                                  state_d = S_PLAYING;
        else if (MCW'(mc_nx_s) >= MCW'(MAX_MISSES)) state_d = S_GAME_OVER;
        else                                        state_d = S_PLAYING;
      end
      S_GAME_OVER: begin
        if (start) state_d = S_PLAYING;
        else       state_d = S_GAME_OVER;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered state flags derived from the next state.
  always_comb begin
    playing_d   = (state_d == S_PLAYING);
    game_over_d = (state_d == S_GAME_OVER);
  end

  // Next values of counters, mask, pulses and edge-detect history.
  always_comb begin
    prev_buttons_d = buttons;
    prev_moles_d   = mole_positions;
    hit_pulse_d    = hit_vec_s;
    miss_pulse_d   = (miss_add_s != '0);
`ifdef MOLE_COMBO_EN
    combo_d        = combo_q;
`endif
    if (start) begin
      score_d      = '0;
      miss_count_d = '0;
      whacked_d    = '0;
`ifdef MOLE_COMBO_EN
      combo_d      = 3'd0;
`endif
    end else if (active_s) begin
      score_d      = score_nx_s[SCORE_WIDTH-1:0];
      miss_count_d = mc_nx_s;
      whacked_d    = (whacked_q | hit_vec_s) & mole_positions;
`ifdef MOLE_COMBO_EN
      if (miss_add_s != '0)   combo_d = 3'd0;
      else if (nh_s != '0)    combo_d = (combo_q >= 3'd4) ? 3'd4 : combo_q + 3'd1;
      else                    combo_d = combo_q;
`endif
    end else begin
      score_d      = score_q;
      miss_count_d = miss_count_q;
      whacked_d    = whacked_q & mole_positions;
    end
  end

  // All state and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      score_q        <= '0;
      miss_count_q   <= '0;
      whacked_q      <= '0;
      hit_pulse_q    <= '0;
      miss_pulse_q   <= 1'b0;
      playing_q      <= 1'b0;
      game_over_q    <= 1'b0;
      prev_buttons_q <= '1;
      prev_moles_q   <= '0;
`ifdef MOLE_COMBO_EN
      combo_q        <= 3'd0;
`endif
    end else begin
      state_q        <= state_d;
      score_q        <= score_d;
      miss_count_q   <= miss_count_d;
      whacked_q      <= whacked_d;
      hit_pulse_q    <= hit_pulse_d;
      miss_pulse_q   <= miss_pulse_d;
      playing_q      <= playing_d;
      game_over_q    <= game_over_d;
      prev_buttons_q <= prev_buttons_d;
      prev_moles_q   <= prev_moles_d;
`ifdef MOLE_COMBO_EN
      combo_q        <= combo_d;
`endif
    end
  end

  assign score      = score_q;
  assign miss_count = miss_count_q;
  assign whacked    = whacked_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;
  assign playing    = playing_q;
  assign game_over  = game_over_q;
`ifdef MOLE_COMBO_EN
  assign combo      = combo_q;
`endif

endmodule

// File: tb/tb_mole_hit_detector.sv
// Self-checking bench for mole_hit_detector: a table of input/expected records
// plus hand-built sequences for saturation, combo scoring and mid-game reset.
module tb_mole_hit_detector;

  localparam int NH = 18;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [NH-1:0] mole_positions, buttons;
  logic [9:0]    score;
  logic [2:0]    miss_count;
  logic [NH-1:0] whacked, hit_pulse;
  logic          miss_pulse, playing, game_over;
`ifdef MOLE_COMBO_EN
  logic [2:0]    combo;
`endif

  always #5 clk = ~clk;

  mole_hit_detector dut (
    .clk(clk), .reset(reset), .start(start),
    .mole_positions(mole_positions), .buttons(buttons),
    .score(score), .miss_count(miss_count), .whacked(whacked),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .playing(playing), .game_over(game_over)
`ifdef MOLE_COMBO_EN
    , .combo(combo)
`endif
  );

  typedef struct packed {
    logic [15:0]   id;
    logic          rst;
    logic          st;
    logic [NH-1:0] m;
    logic [NH-1:0] b;
    logic [9:0]    sc;
    logic [2:0]    mc;
    logic [NH-1:0] wh;
    logic [NH-1:0] hit;
    logic          mp;
    logic          pl;
    logic          go;
    logic          chk_combo;
    logic [2:0]    cb;
  } vec_t;

  vec_t tbl [25];
  vec_t exp_q [$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   seq_id = 0;

  function automatic vec_t mk(input logic r, input logic s, input logic [NH-1:0] m,
                              input logic [NH-1:0] b, input int sc, input int mc,
                              input logic [NH-1:0] wh, input logic [NH-1:0] hit,
                              input logic mp, input logic pl, input logic go);
    vec_t v;
    v = '0;
    v.rst = r; v.st = s; v.m = m; v.b = b;
    v.sc = 10'(sc); v.mc = 3'(mc); v.wh = wh; v.hit = hit;
    v.mp = mp; v.pl = pl; v.go = go;
    return v;
  endfunction

  task automatic cmp(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s vec%0d: got %0h, expected %0h", nm, id, got, want);
    end
  endtask

  task automatic check();
    vec_t e;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      e = exp_q.pop_front();
      n_vec++;
      cmp("score",      int'(e.id), 32'(score),      32'(e.sc));
      cmp("miss_count", int'(e.id), 32'(miss_count), 32'(e.mc));
      cmp("whacked",    int'(e.id), 32'(whacked),    32'(e.wh));
      cmp("hit_pulse",  int'(e.id), 32'(hit_pulse),  32'(e.hit));
      cmp("miss_pulse", int'(e.id), 32'(miss_pulse), 32'(e.mp));
      cmp("playing",    int'(e.id), 32'(playing),    32'(e.pl));
      cmp("game_over",  int'(e.id), 32'(game_over),  32'(e.go));
`ifdef MOLE_COMBO_EN
      if (e.chk_combo) cmp("combo", int'(e.id), 32'(combo), 32'(e.cb));
`endif
    end
  endtask

  task automatic apply(input vec_t v);
    v.id = 16'(seq_id);
    seq_id++;
    reset = v.rst; start = v.st; mole_positions = v.m; buttons = v.b;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    vec_t v;
    int   exp_score;
    int   exp_combo;
    int   mult;
    logic [NH-1:0] all1;

    all1 = '1;
    reset = 1'b1; start = 1'b0; mole_positions = '0; buttons = '0;

    //             rst  st   moles     buttons   sc mc whacked   hit       mp   pl   go
    tbl[0]  = mk(1'b1,1'b0,18'h00000,18'h00008, 0,0,18'h00000,18'h00000,1'b0,1'b0,1'b0);
    tbl[1]  = mk(1'b1,1'b0,18'h00000,18'h00008, 0,0,18'h00000,18'h00000,1'b0,1'b0,1'b0);
    tbl[2]  = mk(1'b0,1'b1,18'h00008,18'h00008, 0,0,18'h00000,18'h00000,1'b0,1'b1,1'b0);
    tbl[3]  = mk(1'b0,1'b0,18'h00008,18'h00008, 0,0,18'h00000,18'h00000,1'b0,1'b1,1'b0);
    tbl[4]  = mk(1'b0,1'b0,18'h00008,18'h00000, 0,0,18'h00000,18'h00000,1'b0,1'b1,1'b0);
    tbl[5]  = mk(1'b0,1'b0,18'h00008,18'h00008, 1,0,18'h00008,18'h00008,1'b0,1'b1,1'b0);
    tbl[6]  = mk(1'b0,1'b0,18'h00008,18'h00008, 1,0,18'h00008,18'h00000,1'b0,1'b1,1'b0);
    tbl[7]  = mk(1'b0,1'b1,18'h00020,18'h00000, 0,0,18'h00000,18'h00000,1'b0,1'b1,1'b0);
    tbl[8]  = mk(1'b0,1'b0,18'h00020,18'h00020, 1,0,18'h00020,18'h00020,1'b0,1'b1,1'b0);
    tbl[9]  = mk(1'b0,1'b0,18'h00020,18'h00000, 1,0,18'h00020,18'h00000,1'b0,1'b1,1'b0);
    tbl[10] = mk(1'b0,1'b0,18'h00020,18'h00020, 0,1,18'h00020,18'h00000,1'b1,1'b1,1'b0);
    tbl[11] = mk(1'b0,1'b0,18'h00020,18'h00000, 0,1,18'h00020,18'h00000,1'b0,1'b1,1'b0);
    tbl[12] = mk(1'b0,1'b0,18'h00884,18'h00000, 0,1,18'h00000,18'h00000,1'b0,1'b1,1'b0);
    tbl[13] = mk(1'b0,1'b0,18'h00884,18'h00094, 1,2,18'h00084,18'h00084,1'b1,1'b1,1'b0);
    tbl[14] = mk(1'b0,1'b0,18'h00884,18'h00000, 1,2,18'h00084,18'h00000,1'b0,1'b1,1'b0);
    tbl[15] = mk(1'b0,1'b0,18'h00000,18'h00000, 1,3,18'h00000,18'h00000,1'b1,1'b1,1'b0);
    tbl[16] = mk(1'b0,1'b0,18'h00200,18'h00000, 1,3,18'h00000,18'h00000,1'b0,1'b1,1'b0);
    tbl[17] = mk(1'b0,1'b0,18'h00000,18'h00000, 1,4,18'h00000,18'h00000,1'b1,1'b1,1'b0);
    tbl[18] = mk(1'b0,1'b0,18'h00000,18'h00001, 0,5,18'h00000,18'h00000,1'b1,1'b0,1'b1);
    tbl[19] = mk(1'b0,1'b0,18'h00002,18'h00000, 0,5,18'h00000,18'h00000,1'b0,1'b0,1'b1);
    tbl[20] = mk(1'b0,1'b0,18'h00002,18'h00002, 0,5,18'h00000,18'h00000,1'b0,1'b0,1'b1);
    tbl[21] = mk(1'b0,1'b0,18'h00000,18'h00000, 0,5,18'h00000,18'h00000,1'b0,1'b0,1'b1);
    tbl[22] = mk(1'b0,1'b1,18'h00000,18'h00000, 0,0,18'h00000,18'h00000,1'b0,1'b1,1'b0);
    tbl[23] = mk(1'b0,1'b0,18'h00000,18'h00001, 0,1,18'h00000,18'h00000,1'b1,1'b1,1'b0);
    tbl[24] = mk(1'b0,1'b0,18'h00000,18'h00000, 0,1,18'h00000,18'h00000,1'b0,1'b1,1'b0);

    for (int i = 0; i < 25; i++) begin
      apply(tbl[i]);
    end

    // High-side saturation: repeated 18-hole hit rounds until score pins at 1023.
    v = mk(1'b0,1'b1,18'h0,18'h0, 0,0,18'h0,18'h0,1'b0,1'b1,1'b0);
    v.chk_combo = 1'b1; v.cb = 3'd0;
    apply(v);
    exp_score = 0;
    exp_combo = 0;
    for (int r = 0; r < 60; r++) begin
      mult = 1;
`ifdef MOLE_COMBO_EN
      mult = (exp_combo <= 1) ? 1 : ((exp_combo <= 3) ? 2 : 4);
`endif
      exp_score = exp_score + 18 * mult;
      if (exp_score > 1023) exp_score = 1023;
      exp_combo = (exp_combo >= 4) ? 4 : exp_combo + 1;
      v = mk(1'b0,1'b0,all1,all1, exp_score,0,all1,all1,1'b0,1'b1,1'b0);
      v.chk_combo = 1'b1; v.cb = 3'(exp_combo);
      apply(v);
      v = mk(1'b0,1'b0,18'h0,18'h0, exp_score,0,18'h0,18'h0,1'b0,1'b1,1'b0);
      v.chk_combo = 1'b1; v.cb = 3'(exp_combo);
      apply(v);
    end
    cmp("score_pinned_at_max", 999, 32'(score), 32'd1023);

    // Five consecutive hit cycles on holes 0..4, one new press per cycle.
    v = mk(1'b0,1'b1,18'h0001F,18'h0, 0,0,18'h0,18'h0,1'b0,1'b1,1'b0);
    v.chk_combo = 1'b1; v.cb = 3'd0;
    apply(v);
    exp_score = 0;
    for (int k = 0; k < 5; k++) begin
`ifdef MOLE_COMBO_EN
      exp_score = exp_score + ((k < 2) ? 1 : ((k < 4) ? 2 : 4));
`else
      exp_score = exp_score + 1;
`endif
      v = mk(1'b0,1'b0,18'h0001F,NH'((1 << (k + 1)) - 1), exp_score,0,
             NH'((1 << (k + 1)) - 1),NH'(1 << k),1'b0,1'b1,1'b0);
      v.chk_combo = 1'b1; v.cb = 3'((k >= 3) ? 4 : k + 1);
      apply(v);
    end

    // Reset mid-game with buttons held, then release: held buttons are not presses.
    v = mk(1'b1,1'b0,18'h0001F,18'h0001F, 0,0,18'h0,18'h0,1'b0,1'b0,1'b0);
    v.chk_combo = 1'b1; v.cb = 3'd0;
    apply(v);
    v = mk(1'b0,1'b0,18'h0001F,18'h0001F, 0,0,18'h0,18'h0,1'b0,1'b0,1'b0);
    v.chk_combo = 1'b1; v.cb = 3'd0;
    apply(v);

    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
